// File: rtl/fnd_pkg.sv
// Shared constants, conversion state encoding and the double-dabble nibble adjust
// used by the FND digit scanner.
package fnd_pkg;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int ITER_W = 4;

    localparam logic [BIN_W-1:0]  BCD_MAX   = 14'd9999;
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(BIN_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } conv_state_t;

    // Add 3 to every nibble >= 5 so that the following left shift carries into the next decade
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one shift per cycle, BIN_W iterations per load.
// done pulses during the final iteration; bcd_next holds the completed result in that cycle.
module bin2bcd_serial
    import fnd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BIN_W-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd_next
);

    conv_state_t       state, state_n;
    logic [ITER_W-1:0] iter, iter_n;
    logic [BIN_W-1:0]  bin_q, bin_n;
    logic [BCD_W-1:0]  bcd_q, bcd_n;
    logic [BCD_W+BIN_W-1:0] shifted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            iter  <= '0;
            bin_q <= '0;
            bcd_q <= '0;
        end else begin
            state <= state_n;
            iter  <= iter_n;
            bin_q <= bin_n;
            bcd_q <= bcd_n;
        end
    end

    always_comb begin
        state_n = state;
        iter_n  = iter;
        bin_n   = bin_q;
        bcd_n   = bcd_q;
        done    = 1'b0;
        shifted = {bcd_adjust(bcd_q), bin_q} << 1;
        case (state)
            IDLE: begin
                if (load) begin
                    bin_n   = (value > BCD_MAX) ? BCD_MAX : value;
                    bcd_n   = '0;
                    iter_n  = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_n, bin_n} = shifted;
                iter_n         = iter + 1'b1;
                if (iter == ITER_LAST) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy     = (state == SHIFT);
    assign bcd_next = shifted[BCD_W+BIN_W-1:BIN_W];

endmodule

// File: rtl/fnd_digit_scanner.sv
// 4-digit 7-segment scan front end: binary load -> BCD, refresh prescaler,
// digit rotation and leading-zero blanking for the downstream 2-to-4 decoder.
module fnd_digit_scanner
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000,
    parameter bit LZB      = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [BIN_W-1:0] i_value,
    output logic             o_busy,
    output logic [1:0]       o_digitSelect,
    output logic [3:0]       o_bcd,
    output logic             o_blank
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0]            presc;
    logic                        tick;
    logic [DIGITS-1:0][3:0]      disp;
    logic                        conv_done;
    logic [BCD_W-1:0]            conv_bcd;
    logic [DIGITS-1:0]           zero_from;

    bin2bcd_serial u_conv (
        .clk      (i_clk),
        .reset    (i_reset),
        .load     (i_load),
        .value    (i_value),
        .busy     (o_busy),
        .done     (conv_done),
        .bcd_next (conv_bcd)
    );

    assign tick = i_enable && (presc == CNT_LAST);

    // Prescaler and digit counter freeze together when disabled so the scan resumes in phase
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            presc         <= '0;
            o_digitSelect <= '0;
        end else if (i_enable) begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                o_digitSelect <= o_digitSelect + 2'd1;
        end
    end

    // All four digits update on the same edge; the scan never sees a partial value
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            disp <= '0;
        else if (conv_done)
            disp <= conv_bcd;
    end

    // zero_from[k] = digits DIGITS-1 down to k are all zero
    always_comb begin
        zero_from = '0;
        zero_from[DIGITS-1] = (disp[DIGITS-1] == 4'd0);
        for (int k = DIGITS-2; k >= 0; k--)
            zero_from[k] = zero_from[k+1] && (disp[k] == 4'd0);
    end

    assign o_bcd   = disp[o_digitSelect];
    assign o_blank = ~i_enable |
                     (LZB && (o_digitSelect != 2'd0) && zero_from[o_digitSelect]);

endmodule
